// File: rtl/bit_reversal_stream.sv
// Streaming bit-reversal reorder buffer: ping-pong banks of N complex samples, natural order in, bit-reversed order out.
// Optional BITREV_BYPASS_EN adds a per-frame bypass input that selects natural-order readout for that frame.
module bit_reversal_stream #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_first,
  output logic              out_last,
  output logic              frame_done
`ifdef BITREV_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  if (LOG2N < 2 || LOG2N > 10) begin : g_bad_log2n
    $error("bit_reversal_stream: LOG2N must be in 2..10");
  end

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [2*DATA_W-1:0] mem [2][N];
  logic                wbank;
  logic                rbank;
  logic [LOG2N-1:0]    wcnt;
  logic [LOG2N-1:0]    rcnt;
  logic [1:0]          full;
  logic                wr_fire;
  logic                rd_fire;
  logic [LOG2N-1:0]    rd_addr;
  logic [2*DATA_W-1:0] rd_word;

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Sample storage is deliberately left unreset; the full flags decide what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wbank][wcnt] <= {in_real, in_imag};
    end
  end

`ifdef BITREV_BYPASS_EN
  logic [1:0] mode_byp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_byp <= 2'b00;
    end else if (wr_fire && wcnt == '0) begin
      mode_byp[wbank] <= bypass;
    end
  end

  assign rd_addr = mode_byp[rbank] ? rcnt : bitrev(rcnt);
`else
  assign rd_addr = bitrev(rcnt);
`endif

  // Write and read never own the same bank, so a set and a clear of full[] in one cycle cannot collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      full       <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_fire) begin
        wcnt <= wcnt + ONE;
        if (wcnt == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + ONE;
        if (rcnt == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= !rbank;
          frame_done  <= 1'b1;
        end
      end
    end
  end

  assign rd_word   = mem[rbank][rd_addr];
  assign out_real  = out_valid ? rd_word[2*DATA_W-1:DATA_W] : '0;
  assign out_imag  = out_valid ? rd_word[DATA_W-1:0] : '0;
  assign out_first = out_valid && (rcnt == '0);
  assign out_last  = out_valid && (rcnt == LAST);

endmodule

// File: tb/tb_bit_reversal_stream.sv
// Directed bench for bit_reversal_stream: 16-point streaming, backpressure, mid-frame reset and an 8-point instance.
// Expected output order comes from hand-written bit-reversal tables.
module tb_bit_reversal_stream;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_real, in_imag, out_real, out_imag;
  logic          out_first, out_last, frame_done;
  logic          bypass;

  logic          in_valid_8, in_ready_8, out_valid_8, out_ready_8;
  logic [DW-1:0] in_real_8, in_imag_8, out_real_8, out_imag_8;
  logic          out_first_8, out_last_8, frame_done_8;

  int checks = 0;
  int errors = 0;
  bit pending_done = 1'b0;

  int rev16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int rev8  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  bit_reversal_stream #(.DATA_W(DW), .LOG2N(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_first  (out_first),
    .out_last   (out_last),
    .frame_done (frame_done)
`ifdef BITREV_BYPASS_EN
    ,
    .bypass     (bypass)
`endif
  );

  bit_reversal_stream #(.DATA_W(DW), .LOG2N(3)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid_8),
    .in_ready   (in_ready_8),
    .in_real    (in_real_8),
    .in_imag    (in_imag_8),
    .out_valid  (out_valid_8),
    .out_ready  (out_ready_8),
    .out_real   (out_real_8),
    .out_imag   (out_imag_8),
    .out_first  (out_first_8),
    .out_last   (out_last_8),
    .frame_done (frame_done_8)
`ifdef BITREV_BYPASS_EN
    ,
    .bypass     (1'b0)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Streams nframes ramp frames starting at base; out_ready held low for the first hold cycles.
  // Bit f of byp_mask marks frame f as natural-order (bypass builds only).
  task automatic applyStimulus(input int nframes, input int base, input int hold, input int byp_mask);
    int total = nframes * 16;
    int in_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    int fin, fout, pos, exp_val;
    bit exp_valid, exp_ready, natural;
    logic [DW-1:0] ev;
    while (out_cnt < total && cyc < 4000) begin
      @(negedge clk);
      out_ready = (cyc >= hold);
      in_valid  = (in_cnt < total);
      in_real   = DW'(base + in_cnt);
      in_imag   = -in_real;
      bypass    = ((byp_mask >> (in_cnt / 16)) & 1) != 0;
      if (in_cnt % 16 != 0) bypass = !bypass;

      fin       = in_cnt / 16;
      fout      = out_cnt / 16;
      pos       = out_cnt % 16;
      exp_valid = fin > fout;
      exp_ready = (fin - fout) < 2;
      natural   = ((byp_mask >> fout) & 1) != 0;
      exp_val   = base + fout * 16 + (natural ? pos : rev16[pos]);
      ev        = exp_valid ? DW'(exp_val) : '0;

      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("out_real", 32'(out_real), 32'(ev));
      checkOutput("out_imag", 32'(out_imag), 32'(DW'(-ev)));
      checkOutput("out_first", 32'(out_first), 32'(exp_valid && pos == 0));
      checkOutput("out_last", 32'(out_last), 32'(exp_valid && pos == 15));
      checkOutput("frame_done", 32'(frame_done), 32'(pending_done));
      if (hold > 0 && cyc == hold) checkOutput("bp_accepted", 32'(in_cnt), 32'd32);

      pending_done = exp_valid && out_ready && pos == 15;
      if (in_valid && in_ready) in_cnt++;
      if (out_valid && out_ready) out_cnt++;
      cyc++;
    end
    checkOutput("stream_complete", 32'(out_cnt), 32'(total));
  endtask

  task automatic runSmallFrame();
    int in_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    out_ready_8 = 1'b1;
    while (out_cnt < 8 && cyc < 100) begin
      @(negedge clk);
      in_valid_8 = (in_cnt < 8);
      in_real_8  = DW'(in_cnt);
      in_imag_8  = -in_real_8;
      if (out_valid_8) begin
        checkOutput("l3_real", 32'(out_real_8), 32'(rev8[out_cnt]));
        checkOutput("l3_first", 32'(out_first_8), 32'(out_cnt == 0));
        checkOutput("l3_last", 32'(out_last_8), 32'(out_cnt == 7));
        out_cnt++;
      end
      if (in_valid_8 && in_ready_8) in_cnt++;
      cyc++;
    end
    checkOutput("l3_complete", 32'(out_cnt), 32'd8);
    @(negedge clk);
    in_valid_8 = 1'b0;
    checkOutput("l3_frame_done", 32'(frame_done_8), 32'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_real     = '0;
    in_imag     = '0;
    out_ready   = 1'b0;
    bypass      = 1'b0;
    in_valid_8  = 1'b0;
    in_real_8   = '0;
    in_imag_8   = '0;
    out_ready_8 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_real", 32'(out_real), 32'd0);
    checkOutput("rst_out_first", 32'(out_first), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(3, 0, 0, 0);
    applyStimulus(2, 0, 45, 0);

    // Fill one bank plus 7 samples with the output stalled, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_real  = DW'(i);
      in_imag  = -in_real;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_out_real", 32'(out_real), 32'd0);
    checkOutput("async_out_imag", 32'(out_imag), 32'd0);
    checkOutput("async_out_first", 32'(out_first), 32'd0);
    checkOutput("async_out_last", 32'(out_last), 32'd0);
    checkOutput("async_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pending_done = 1'b0;
    applyStimulus(1, 100, 0, 0);

    runSmallFrame();

`ifdef BITREV_BYPASS_EN
    applyStimulus(2, 0, 0, 1);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_reversal_stream.md
# bit_reversal_stream

Parametrised streaming bit-reversal reorder buffer for the FFT datapath. Accepts complex samples one per cycle in natural order over a valid/ready handshake and emits each N-point frame in bit-reversed index order. Ping-pong banking sustains one sample per cycle with back-to-back frames. Replaces the fixed 16-point, 256-bit-parallel reorder stage between the sample front end and the butterfly core.

## Interface

Parameters:
- DATA_W, 16, width of each real/imag component (two's complement)
- LOG2N, 4, log2 of frame length N; legal range 2..10

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample
- in_real  input  DATA_W  real component, natural order
- in_imag  input  DATA_W  imag component, natural order
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts sample
- out_real  output  DATA_W  real component, reordered
- out_imag  output  DATA_W  imag component, reordered
- out_first  output  1  high with sample 0 of an output frame
- out_last  output  1  high with sample N-1 of an output frame
- frame_done  output  1  one-cycle pulse after a frame fully drains
- bypass  input  1  present only with BITREV_BYPASS_EN (see Configuration)

## Operation

- Storage: two banks of N entries, each 2*DATA_W bits (flops), plus per-bank full flag; contents not reset.
- Write side: wbank pointer, wcnt (LOG2N bits). in_ready = !full[wbank]. On in_valid && in_ready: mem[wbank][wcnt] <= {in_real,in_imag}; wcnt++. When accepted write has wcnt == N-1: full[wbank] <= 1, wbank toggles, wcnt wraps to 0.
- Read side: rbank pointer, rcnt (LOG2N bits). out_valid = full[rbank]. Read address = bitrev(rcnt) (LOG2N-bit reversal), combinational read. out_real/out_imag = stored value when out_valid, else 0. out_first = out_valid && rcnt == 0; out_last = out_valid && rcnt == N-1.
- On out_valid && out_ready: rcnt++. When rcnt == N-1: full[rbank] <= 0, rbank toggles, rcnt wraps, frame_done <= 1 next cycle.
- Bank states per bank: EMPTY (full=0, not wbank), FILLING (wbank, full=0), FULL (full=1, waiting/draining). Write and read never target the same bank concurrently; set of full[a] and clear of full[b] in one cycle both take effect.
- A bank released by the read side becomes writable the following cycle only (in_ready derives from registered flags; no same-cycle pass-through).
- Data passes unmodified; no arithmetic, no sign change.
- in_valid while in_ready low: sample not taken; upstream must hold it.
- Output holds stable (data, out_first, out_last) while out_valid && !out_ready.

## Timing

- Reset (reset_n low, asynchronous): wbank=rbank=0, wcnt=rcnt=0, full flags 0. Outputs: in_ready 1, out_valid 0, out_real/out_imag 0, out_first 0, out_last 0, frame_done 0. Applies mid-frame: partial and stored frames are discarded.
- Latency: first sample of a frame valid on out_valid the cycle after the frame's last input is accepted.
- Throughput: 1 sample/cycle sustained with out_ready held high; in_ready never drops.
- Backpressure: with out_ready low, block absorbs exactly 2N samples then deasserts in_ready.
- frame_done: registered, high exactly one cycle, the cycle after the out_last handshake.

## Configuration

- BITREV_BYPASS_EN defined: bypass port exists. Sampled on the accepted write with wcnt == 0 and stored per bank; a bank marked bypass reads at address rcnt (natural order). Mode changes only at frame boundaries; bypass ignored on other samples. Reset clears stored mode bits to 0.
- Undefined: no bypass port, no mode bits; every frame bit-reversed.

## Test plan

- LOG2N=4, in_real = 0..15, in_imag = 0, out_ready=1 -> out_real 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_first on 0, out_last on 15, frame_done pulse 1 cycle later.
- Three back-to-back frames (ramps 0..15, 16..31, 32..47), out_ready=1 -> in_ready constantly 1, out_valid gapless after first frame, each frame bit-reversed; in_imag = -in_real reproduced exactly (e.g. -8 with real 8).
- out_ready=0 held -> in_ready drops after 32 accepted samples; out_valid=1 with out_real=0 stable; raising out_ready drains 0,8,4,... then 16,24,20,...
- reset_n pulsed low after 7 of 16 samples -> all outputs to reset values immediately; fresh ramp 0..15 then yields 0,8,4,12,... with no stale data.
- LOG2N=3, ramp 0..7 -> 0,4,2,6,1,5,3,7.
- BITREV_BYPASS_EN, frame A bypass=1, frame B bypass=0, ramp 0..15 each -> A outputs 0..15 natural, B outputs 0,8,4,12,...; bypass toggled mid-frame has no effect.
